// File: rtl/command_controller_pkg.sv
// command_controller_pkg: command/response codes, FSM states and sensor response decode
package command_controller_pkg;
  localparam logic [7:0] CMD_PING = 8'h00, CMD_TEMP = 8'h01, CMD_HUM = 8'h02;
  localparam logic [7:0] RSP_PING = 8'h07, RSP_HUM = 8'h08, RSP_TEMP = 8'h09;
  localparam logic [7:0] RSP_FAIL = 8'h1F, RSP_BAD_CMD = 8'hCF, RSP_BAD_ADDR = 8'hEF;
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_ADDR, S_CHECK, S_REQ_SENSOR, S_WAIT_SENSOR,
    S_SEND_CODE, S_WAIT_CODE, S_SEND_VALUE, S_WAIT_VALUE
  } state_t;
  // {code, value} for a completed read; the checksum is an 8-bit wrapping sum
  function automatic logic [15:0] sensor_response(input logic [7:0] cmd, input logic err, input logic [39:0] data);
    logic [7:0] sum;
    sum = data[39:32] + data[31:24] + data[23:16] + data[15:8];
    if (err || sum != data[7:0]) return {RSP_FAIL, 8'h00};
    return cmd == CMD_TEMP ? {RSP_TEMP, data[23:16]} : cmd == CMD_HUM ? {RSP_HUM, data[39:32]} : {RSP_PING, 8'h00};
  endfunction
endpackage

// File: rtl/command_controller_if.sv
// command_controller_if: UART byte, sensor and status signals of the command controller
interface command_controller_if;
  logic        rx_done;
  logic [7:0]  rx_byte;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        sensor_req;
  logic [4:0]  sensor_addr;
  logic        sensor_done;
  logic        sensor_error;
  logic [39:0] sensor_data;
  logic        busy;
  modport master (
    input  rx_done, rx_byte, tx_busy, sensor_done, sensor_error, sensor_data,
    output tx_start, tx_byte, sensor_req, sensor_addr, busy
  );
  modport slave (
    output rx_done, rx_byte, tx_busy, sensor_done, sensor_error, sensor_data,
    input  tx_start, tx_byte, sensor_req, sensor_addr, busy
  );
endinterface

// File: rtl/command_controller_timeout_counter.sv
// timeout_counter: counts enabled cycles since clear; expired on the limit-th enabled cycle
module timeout_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [31:0] i_limit,
  output logic        o_expired
);
  logic [31:0] r_count;
  always_ff @(posedge clock) begin
    if (reset || i_clear) r_count <= '0;
    else if (i_enable && !o_expired) r_count <= r_count + 32'd1;
  end
  assign o_expired = i_enable && r_count >= i_limit - 32'd1;
endmodule

// File: rtl/command_controller.sv
// command_controller: UART command/address decode, one sensor read, two-byte response
module command_controller
  import command_controller_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned BYTE_TIMEOUT   = 50000000,
  parameter int unsigned SENSOR_TIMEOUT = 100000000,
  parameter int unsigned NUM_ADDR       = 32
) (
  input logic                  clock,
  input logic                  reset,
  command_controller_if.master bus
);
  if (CLK_HZ == 0) begin : g_bad_clk
    $error("CLK_HZ must be nonzero");
  end
  state_t      r_state;
  logic [7:0]  r_cmd, r_addr, r_code, r_val;
  logic        w_byte_exp, w_sensor_exp, w_cmd_ok;
  logic [15:0] w_rsp;
  timeout_counter u_byte_timer (
    .clock, .reset, .i_clear(r_state != S_WAIT_ADDR), .i_enable(r_state == S_WAIT_ADDR),
    .i_limit(BYTE_TIMEOUT), .o_expired(w_byte_exp)
  );
  timeout_counter u_sensor_timer (
    .clock, .reset, .i_clear(r_state != S_WAIT_SENSOR), .i_enable(r_state == S_WAIT_SENSOR),
    .i_limit(SENSOR_TIMEOUT), .o_expired(w_sensor_exp)
  );
  assign w_cmd_ok = r_cmd inside {CMD_PING, CMD_TEMP, CMD_HUM};
  assign w_rsp    = sensor_response(r_cmd, bus.sensor_error, bus.sensor_data);
  assign bus.busy = r_state != S_IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cmd           <= '0;
      r_addr          <= '0;
      r_code          <= '0;
      r_val           <= '0;
      bus.tx_start    <= 1'b0;
      bus.tx_byte     <= '0;
      bus.sensor_req  <= 1'b0;
      bus.sensor_addr <= '0;
    end else begin
      bus.tx_start <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.rx_done) begin
          r_cmd   <= bus.rx_byte;
          r_state <= S_WAIT_ADDR;
        end
        S_WAIT_ADDR: if (bus.rx_done) begin
          r_addr  <= bus.rx_byte;
          r_state <= S_CHECK;
        end else if (w_byte_exp) r_state <= S_IDLE;
        S_CHECK: begin
          r_code  <= w_cmd_ok ? RSP_BAD_ADDR : RSP_BAD_CMD;
          r_val   <= 8'h00;
          r_state <= !w_cmd_ok || 32'(r_addr) >= NUM_ADDR ? S_SEND_CODE : S_REQ_SENSOR;
        end
        S_REQ_SENSOR: begin
          bus.sensor_req  <= 1'b1;
          bus.sensor_addr <= r_addr[4:0];
          r_state         <= S_WAIT_SENSOR;
        end
        // done in the expiry cycle still counts as a completed read
        S_WAIT_SENSOR: if (bus.sensor_done || w_sensor_exp) begin
          bus.sensor_req  <= 1'b0;
          {r_code, r_val} <= bus.sensor_done ? w_rsp : {RSP_FAIL, 8'h00};
          r_state         <= S_SEND_CODE;
        end
        S_SEND_CODE, S_SEND_VALUE: if (!bus.tx_busy) begin
          bus.tx_start <= 1'b1;
          bus.tx_byte  <= r_state == S_SEND_CODE ? r_code : r_val;
          r_state      <= r_state == S_SEND_CODE ? S_WAIT_CODE : S_WAIT_VALUE;
        end
        // tx_start still high marks the first wait cycle, where tx_busy is not yet trusted
        S_WAIT_CODE, S_WAIT_VALUE: if (!bus.tx_start && !bus.tx_busy)
          r_state <= r_state == S_WAIT_CODE ? S_SEND_VALUE : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_command_controller.sv
// tb_command_controller: directed transactions checked against a transaction-level response model
module tb_command_controller;
  localparam int BT = 20, ST = 30, NA = 32, TX_HOLD = 6;
  logic clock = 0, reset = 1;
  logic mdl_busy = 0, ext_busy = 0;
  command_controller_if bus();
  command_controller #(.CLK_HZ(1000), .BYTE_TIMEOUT(BT), .SENSOR_TIMEOUT(ST), .NUM_ADDR(NA)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  assign bus.tx_busy = mdl_busy | ext_busy;
  always #5 clock = ~clock;

  int n_pass = 0, n_total = 0;
  logic [7:0] exp_q[$];
  logic [4:0] addr_q[$];
  int resp_delay = 0;
  logic [39:0] resp_data = 0;
  logic resp_err = 0;
  int cyc = 0, rise_cyc = 0, last_len = 0;
  bit len_valid = 0;
  logic req_d = 0, hold = 0, rsp_req_d = 0;
  logic [7:0] held = 0;
  logic [4:0] req_addr = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Response from the rules: bad command beats bad address; any read failure gives 1F
  function automatic logic [15:0] model(input int cmd, input int addr, input int delay,
                                        input logic [39:0] d, input logic err);
    int sum;
    if (cmd > 2) return 16'hCF00;
    if (addr >= NA) return 16'hEF00;
    sum = int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]);
    if (delay < 0 || delay >= ST || err || sum % 256 != int'(d[7:0])) return 16'h1F00;
    return cmd == 0 ? 16'h0700 : cmd == 1 ? {8'h09, d[23:16]} : {8'h08, d[39:32]};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.rx_done = 1;
    bus.rx_byte = b;
    @(negedge clock);
    bus.rx_done = 0;
  endtask

  task automatic do_reset();
    bus.rx_done = 0;
    reset = 1;
    @(negedge clock);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_sensor_req", bus.sensor_req, 0);
    chk("rst_sensor_addr", bus.sensor_addr, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 0;
    exp_q.delete();
    addr_q.delete();
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] addr, input int gap, input int delay,
                     input logic [39:0] d, input logic err, input int abort);
    logic [15:0] r;
    bit sens;
    int lim;
    r = model(cmd, addr, delay, d, err);
    sens = cmd <= 2 && addr < NA;
    resp_delay = delay; resp_data = d; resp_err = err; len_valid = 0;
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
    if (sens) addr_q.push_back(addr[4:0]);
    send_byte(cmd);
    repeat (gap) @(negedge clock);
    send_byte(addr);
    lim = 0;
    if (abort == 1) begin
      while (!bus.sensor_req && lim < 50) begin @(negedge clock); lim++; end
      repeat (3) @(negedge clock);
      chk("abort_in_wait_sensor", bus.sensor_req, 1);
      do_reset();
    end else if (abort == 2) begin
      while (exp_q.size() > 1 && lim < 200) begin @(negedge clock); lim++; end
      @(negedge clock);
      chk("abort_in_wait_code", exp_q.size(), 1);
      do_reset();
    end else begin
      while (bus.busy && lim < 400) begin @(negedge clock); lim++; end
      chk("busy_clears", bus.busy, 0);
      chk("responses_drained", exp_q.size(), 0);
      chk("sensor_addr_consumed", addr_q.size(), 0);
      if (sens) chk("sensor_req_len", len_valid ? last_len : -1, (delay < 0 || delay >= ST) ? ST : delay + 1);
    end
    repeat (10) @(negedge clock);
    chk("idle_after_txn", bus.busy, 0);
  endtask

  // UART model: busy for TX_HOLD cycles after each start
  initial forever begin
    @(negedge clock);
    if (bus.tx_start) begin
      mdl_busy = 1;
      repeat (TX_HOLD) @(negedge clock);
      mdl_busy = 0;
    end
  end

  // Sensor model: answers resp_delay cycles after the request rises, never if negative
  initial forever begin
    @(negedge clock);
    if (bus.sensor_req && !rsp_req_d && resp_delay >= 0) begin
      repeat (resp_delay) @(negedge clock);
      bus.sensor_done = 1;
      bus.sensor_data = resp_data;
      bus.sensor_error = resp_err;
      @(negedge clock);
      bus.sensor_done = 0;
    end
    rsp_req_d = bus.sensor_req;
  end

  // Compare process
  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      req_d = 0;
      hold = 0;
    end else begin
      if (bus.tx_start) begin
        chk("tx_start_needs_idle_uart", bus.tx_busy, 0);
        chk("tx_start_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("tx_byte", bus.tx_byte, exp_q.pop_front());
        hold = 1;
        held = bus.tx_byte;
      end else if (hold) begin
        chk("tx_byte_stable", bus.tx_byte, held);
        if (!bus.tx_busy) hold = 0;
      end
      if (bus.sensor_req && !req_d) begin
        chk("sensor_req_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) chk("sensor_addr", bus.sensor_addr, addr_q.pop_front());
        req_addr = bus.sensor_addr;
        rise_cyc = cyc;
      end else if (bus.sensor_req) chk("sensor_addr_stable", bus.sensor_addr, req_addr);
      if (!bus.sensor_req && req_d) begin
        last_len = cyc - rise_cyc;
        len_valid = 1;
      end
      req_d = bus.sensor_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bus.rx_done = 0; bus.rx_byte = 0;
    bus.sensor_done = 0; bus.sensor_error = 0; bus.sensor_data = 0;
    repeat (2) @(negedge clock);
    do_reset();
    chk("model_temp", model(1, 3, 0, 40'h3700190050, 0), 16'h0919);
    chk("model_bad_sum", model(2, 0, 0, 40'h3700190051, 0), 16'h1F00);
    chk("model_bad_cmd", model(5, 0, 0, 0, 0), 16'hCF00);
    chk("model_bad_addr", model(0, 32, 0, 0, 0), 16'hEF00);
    chk("model_hum", model(2, 0, 0, 40'h3700190050, 0), 16'h0837);
    chk("model_wrap", model(1, 0, 0, 40'hFF02100112, 0), 16'h0910);
    txn(8'h01, 8'h03, 0, 2, 40'h3700190050, 0, 0);
    txn(8'h02, 8'h00, 0, 2, 40'h3700190051, 0, 0);
    txn(8'h05, 8'h00, 0, 0, 0, 0, 0);
    txn(8'h00, 8'h20, 0, 0, 0, 0, 0);
    txn(8'h03, 8'h40, 0, 0, 0, 0, 0);
    txn(8'h02, 8'h1F, BT - 2, 0, 40'h3700190050, 0, 0);
    txn(8'h00, 8'h01, 0, -1, 40'h3700190050, 0, 0);
    txn(8'h01, 8'h04, 0, ST - 1, 40'h3700190050, 0, 0);
    txn(8'h01, 8'h05, 0, ST, 40'h3700190050, 0, 0);
    txn(8'h00, 8'h06, 0, 3, 40'h3700190050, 1, 0);
    txn(8'h01, 8'h07, 0, 1, 40'hFF02100112, 0, 0);
    send_byte(8'h00);
    repeat (BT - 1) @(negedge clock);
    chk("busy_before_byte_timeout", bus.busy, 1);
    @(negedge clock);
    chk("idle_after_byte_timeout", bus.busy, 0);
    repeat (5) @(negedge clock);
    ext_busy = 1;
    fork
      begin
        repeat (8) @(negedge clock);
        send_byte(8'h01);
        repeat (40) @(negedge clock);
        ext_busy = 0;
      end
    join_none
    txn(8'h00, 8'h02, 0, 10, 40'h3700190050, 0, 0);
    txn(8'h01, 8'h08, 0, -1, 40'h3700190050, 0, 1);
    txn(8'h01, 8'h09, 0, 2, 40'h3700190050, 0, 0);
    txn(8'h02, 8'h0A, 0, 2, 40'h3700190050, 0, 2);
    txn(8'h02, 8'h0B, 0, 2, 40'h3700190050, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/command_controller.md
COMMAND_CONTROLLER -- requirements
Module: command_controller

Interface
REQ-001 Parameter CLK_HZ, 50000000, clock frequency in Hz.
REQ-002 Parameter BYTE_TIMEOUT, 50000000, cycles allowed between command byte and address byte.
REQ-003 Parameter SENSOR_TIMEOUT, 100000000, cycles allowed from sensor_req rise to sensor_done.
REQ-004 Parameter NUM_ADDR, 32, number of valid sensor addresses (0..NUM_ADDR-1).
REQ-005 Port clock, input, 1: single clock; all logic rising-edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port rx_done, input, 1: one-cycle pulse, a UART byte has been received.
REQ-008 Port rx_byte, input, 8: received byte, valid in the rx_done cycle.
REQ-009 Port tx_busy, input, 1: UART transmitter busy.
REQ-010 Port tx_start, output, 1: one-cycle pulse requesting transmission of tx_byte.
REQ-011 Port tx_byte, output, 8: byte to transmit, stable from tx_start until tx_busy falls.
REQ-012 Port sensor_req, output, 1: level request for one sensor read.
REQ-013 Port sensor_addr, output, 5: selected sensor address, stable while sensor_req is high.
REQ-014 Port sensor_done, input, 1: one-cycle pulse, read finished.
REQ-015 Port sensor_error, input, 1: read failed, valid in the sensor_done cycle.
REQ-016 Port sensor_data, input, 40: {hum_int, hum_dec, temp_int, temp_dec, checksum}, valid in the sensor_done cycle.
REQ-017 Port busy, output, 1: high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, WAIT_ADDR, CHECK, REQ_SENSOR, WAIT_SENSOR, SEND_CODE, WAIT_CODE, SEND_VALUE, WAIT_VALUE.
REQ-019 IDLE: on rx_done, latch rx_byte as command and go to WAIT_ADDR with the byte timer cleared.
REQ-020 WAIT_ADDR: on rx_done, latch the address and go to CHECK; if the timer reaches BYTE_TIMEOUT first, return to IDLE with no response.
REQ-021 rx_done in any state other than IDLE and WAIT_ADDR is ignored; bytes are not queued.
REQ-022 CHECK (one cycle): a command not in {0x00, 0x01, 0x02} gives response (0xCF, 0x00); an address >= NUM_ADDR gives (0xEF, 0x00); the command check takes priority; otherwise go to REQ_SENSOR.
REQ-023 REQ_SENSOR: assert sensor_req and sensor_addr, clear the sensor timer, go to WAIT_SENSOR; sensor_req stays high until sensor_done or timeout.
REQ-024 WAIT_SENSOR: on sensor_done, drop sensor_req the next cycle and register sensor_data/sensor_error; on reaching SENSOR_TIMEOUT, drop sensor_req and flag a failure.
REQ-025 Checksum valid iff (hum_int + hum_dec + temp_int + temp_dec) mod 256 == checksum, using an 8-bit wrapping sum.
REQ-026 Failure = timeout, sensor_error, or bad checksum; any failure gives response (0x1F, 0x00) for every command.
REQ-027 On success: command 0x00 gives (0x07, 0x00); 0x01 gives (0x09, temp_int); 0x02 gives (0x08, hum_int).
REQ-028 Every accepted command produces exactly two response bytes, code first, then value.
REQ-029 SEND_x: wait until tx_busy == 0, then pulse tx_start one cycle with tx_byte set; the WAIT_x state that follows ignores tx_busy for one cycle, then waits for tx_busy == 0.
REQ-030 After WAIT_VALUE completes, return to IDLE; the first eligible rx_done is one cycle later.
REQ-031 sensor_done arriving in the same cycle as timeout expiry counts as done (done wins).
REQ-032 sensor_done outside WAIT_SENSOR is ignored.

Reset
REQ-033 Reset puts the FSM in IDLE.
REQ-034 Reset drives tx_start=0, tx_byte=0x00, sensor_req=0, sensor_addr=0, busy=0.
REQ-035 Reset clears both timers and all latched registers.
REQ-036 Reset mid-operation aborts immediately with no further tx_start and sensor_req low the next cycle.

Structure
REQ-037 A shared package/include holds command codes 0x00–0x02, response codes 0x07/0x08/0x09/0x1F/0xCF/0xEF, and the state encodings.
REQ-038 A single sub-module, timeout_counter (clear, enable, limit, expired), is instantiated twice: byte timer and sensor timer.

Verification
REQ-039 Send rx 0x01, 0x03; sensor_data=0x3700190050 -> sensor_req with sensor_addr=3; tx bytes 0x09, 0x19.
REQ-040 Send 0x02, 0x00; same data with checksum 0x51 -> tx 0x1F, 0x00.
REQ-041 Send 0x05, 0x00 -> no sensor_req; tx 0xCF, 0x00. Send 0x00, 0x20 -> tx 0xEF, 0x00.
REQ-042 Send 0x00 only, idle BYTE_TIMEOUT cycles -> back to IDLE, busy=0, no tx_start.
REQ-043 Send 0x00, 0x01; never pulse sensor_done -> sensor_req drops at SENSOR_TIMEOUT; tx 0x1F, 0x00; busy=0 after.
REQ-044 Assert reset during WAIT_SENSOR and separately during WAIT_CODE -> all outputs at reset values next cycle; a subsequent valid command completes normally.
